pipeline_flow_ctrl: RTL and testbench
=====================================

Name: pipeline_flow_ctrl

Overview:
- Consumes hazard and control-flow requests from the ID-stage hazard detector and sequences the front end of the 5-stage MIPS pipeline.
- Drives PC write enable, next-PC select, IF/ID hold and flush, ID/EX bubble insertion, and the link-write pulse.
- Holds fetch until a conditional branch resolves in EX, then redirects the PC.
- Keeps saturating stall and flush performance counters, and a sticky error flag for a branch that never resolves.

Parameters:
WAIT_MAX, 4, max BR_WAIT cycles before the timeout path fires (>=1)
CNT_W, 16, width of stall_cnt and flush_cnt

Ports:
clk  in  1  pipeline clock, rising edge
rst  in  1  asynchronous, active-high reset
stall_req  in  1  load-use stall request from hazard detector
branch_req  in  1  conditional branch decoded in ID
jump_req  in  1  unconditional jump decoded in ID
jump_type  in  2  00 JR, 01 JAL, 10 JALR, 11 J
branch_resolved  in  1  EX-stage branch outcome valid
branch_taken  in  1  EX-stage outcome; meaningful only with branch_resolved
pc_write  out  1  PC register load enable
pc_sel  out  2  00 PC+4, 01 branch target, 10 register target, 11 jump immediate target
ifid_write  out  1  IF/ID register load enable
ifid_flush  out  1  load NOP into IF/ID at the next edge
idex_bubble  out  1  load NOP control word into ID/EX
link_write  out  1  one-cycle pulse for a JAL/JALR return-address write
busy  out  1  high while in BR_WAIT
br_timeout_err  out  1  sticky; set by a branch timeout
stall_cnt  out  CNT_W  saturating count of stall cycles
flush_cnt  out  CNT_W  saturating count of cycles with ifid_flush=1

Behaviour:
- States: RUN and BR_WAIT. The state register, wait counter, error flag and counters are registered. All other outputs are combinational from state and inputs, so control takes effect in the same cycle.
- Reset (async, any state): state=RUN, wait_cnt=0, br_timeout_err=0, stall_cnt=0, flush_cnt=0.
- Output values while rst is high: pc_write=0, ifid_write=0, ifid_flush=0, idex_bubble=0, link_write=0, pc_sel=00, busy=0.
- RUN defaults: pc_write=1, ifid_write=1, pc_sel=00; all other outputs 0.
- RUN priority: stall_req > branch_req > jump_req. Lower-priority requests in the same cycle are ignored; the detector re-presents them.
- RUN with stall_req:
  - pc_write=0, ifid_write=0, idex_bubble=1.
  - Stay in RUN; stall_cnt increments.
- RUN with branch_req:
  - pc_write=0, ifid_flush=1.
  - Next state BR_WAIT, wait_cnt cleared to 0.
- RUN with jump_req:
  - pc_write=1, ifid_flush=1, stay in RUN.
  - pc_sel: 10 for JR/JALR, 11 for J/JAL.
  - link_write=1 for JAL (01) and JALR (10), otherwise 0.
- BR_WAIT, branch_resolved=0:
  - pc_write=0, ifid_write=1, ifid_flush=1, busy=1.
  - wait_cnt increments.
  - If wait_cnt==WAIT_MAX-1 this cycle (timeout): pc_write=1, pc_sel=00, br_timeout_err set, next state RUN.
- BR_WAIT, branch_resolved=1:
  - pc_write=1, ifid_flush=1, busy=1.
  - pc_sel=01 if branch_taken, else 00.
  - Next state RUN. Resolution has priority over timeout in the same cycle.
- BR_WAIT ignores stall_req, branch_req and jump_req (ID holds a flushed NOP).
- branch_resolved while in RUN is ignored.
- Counters:
  - flush_cnt increments in every cycle with ifid_flush=1.
  - Both counters saturate at 2^CNT_W-1 and do not wrap.
- br_timeout_err clears only on reset.
- Latency: branch penalty is 1 (entry) + N (wait) cycles, N = cycles until branch_resolved, the resolving cycle included. Jump penalty is 1 flushed slot.

Test Plan:
- Reset asserted mid-BR_WAIT (entered 2 cycles earlier) -> busy drops immediately (async); state RUN; counters and error are 0 after release; pc_write=1, pc_sel=00 on the first RUN cycle.
- stall_req high for 3 cycles, then low -> pc_write=0, ifid_write=0, idex_bubble=1 for exactly 3 cycles; stall_cnt=3; flush_cnt=0.
- branch_req in cycle 0; branch_resolved=1, branch_taken=1 in cycle 2 -> ifid_flush=1 in cycles 0-2; pc_write=0 in cycles 0-1; cycle 2 pc_write=1, pc_sel=01; RUN in cycle 3; flush_cnt=3.
- jump_req with jump_type=01, then jump_type=00 on the next cycle -> cycle 0: pc_sel=11, link_write=1, ifid_flush=1; cycle 1: pc_sel=10, link_write=0; flush_cnt=2.
- branch_req with branch_resolved never asserted, WAIT_MAX=4 -> the 4th BR_WAIT cycle shows pc_write=1, pc_sel=00; br_timeout_err=1 from the next cycle and stays set; state returns to RUN.
- stall_req, branch_req and jump_req together -> stall only (idex_bubble=1, ifid_flush=0, no BR_WAIT entry). Then with CNT_W=2, 5 stall cycles -> stall_cnt holds at 3.

Source files
------------

// File: rtl/pipeline_flow_ctrl.sv
// Front-end flow controller for a 5-stage MIPS pipeline: turns ID-stage hazard and
// control-flow requests into PC/IF-ID/ID-EX control, with branch wait and perf counters.
module pipeline_flow_ctrl #(
  parameter int WAIT_MAX = 4,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_req,
  input  logic             branch_req,
  input  logic             jump_req,
  input  logic [1:0]       jump_type,
  input  logic             branch_resolved,
  input  logic             branch_taken,
  output logic             pc_write,
  output logic [1:0]       pc_sel,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             link_write,
  output logic             busy,
  output logic             br_timeout_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int WW = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
  localparam logic [WW-1:0]    WAIT_LAST = WW'(WAIT_MAX - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  localparam logic [1:0] SEL_PC4  = 2'b00;
  localparam logic [1:0] SEL_BR   = 2'b01;
  localparam logic [1:0] SEL_REG  = 2'b10;
  localparam logic [1:0] SEL_IMM  = 2'b11;

  localparam logic [1:0] JT_JR   = 2'b00;
  localparam logic [1:0] JT_JAL  = 2'b01;
  localparam logic [1:0] JT_JALR = 2'b10;

  typedef enum logic {RUN, BR_WAIT} state_t;

  state_t        state, state_next;
  logic [WW-1:0] wait_cnt, wait_cnt_next;
  logic          err_set;
  logic          stall_take;

  // Outputs are gated off while rst is high so nothing loads during reset.
  always_comb begin
    state_next    = state;
    wait_cnt_next = wait_cnt;
    pc_write      = 1'b0;
    pc_sel        = SEL_PC4;
    ifid_write    = 1'b0;
    ifid_flush    = 1'b0;
    idex_bubble   = 1'b0;
    link_write    = 1'b0;
    busy          = 1'b0;
    err_set       = 1'b0;
    stall_take    = 1'b0;
    if (!rst) begin
      case (state)
        RUN: begin
          pc_write   = 1'b1;
          ifid_write = 1'b1;
          if (stall_req) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
            stall_take  = 1'b1;
          end else if (branch_req) begin
            pc_write      = 1'b0;
            ifid_flush    = 1'b1;
            state_next    = BR_WAIT;
            wait_cnt_next = '0;
          end else if (jump_req) begin
            ifid_flush = 1'b1;
            pc_sel     = (jump_type == JT_JR || jump_type == JT_JALR) ? SEL_REG : SEL_IMM;
            link_write = (jump_type == JT_JAL || jump_type == JT_JALR);
          end
        end
        BR_WAIT: begin
          ifid_write = 1'b1;
          ifid_flush = 1'b1;
          busy       = 1'b1;
          // A resolution arriving on the last wait cycle beats the timeout.
          if (branch_resolved) begin
            pc_write   = 1'b1;
            pc_sel     = branch_taken ? SEL_BR : SEL_PC4;
            state_next = RUN;
          end else begin
            wait_cnt_next = wait_cnt + WW'(1);
            if (wait_cnt == WAIT_LAST) begin
              pc_write   = 1'b1;
              err_set    = 1'b1;
              state_next = RUN;
            end
          end
        end
        default: state_next = RUN;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= RUN;
      wait_cnt       <= '0;
      br_timeout_err <= 1'b0;
      stall_cnt      <= '0;
      flush_cnt      <= '0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_cnt_next;
      if (err_set)
        br_timeout_err <= 1'b1;
      if (stall_take && stall_cnt != CNT_MAX)
        stall_cnt <= stall_cnt + 1'b1;
      if (ifid_flush && flush_cnt != CNT_MAX)
        flush_cnt <= flush_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipeline_flow_ctrl.sv
// Directed bench for pipeline_flow_ctrl: expected control words are queued when each
// step is driven and popped for comparison mid-cycle; a CNT_W=2 copy checks saturation.
module tb_pipeline_flow_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       stall_req, branch_req, jump_req, branch_resolved, branch_taken;
  logic [1:0] jump_type;

  logic        pc_write, ifid_write, ifid_flush, idex_bubble, link_write, busy, br_timeout_err;
  logic [1:0]  pc_sel;
  logic [15:0] stall_cnt, flush_cnt;

  logic        s_pc_write, s_ifid_write, s_ifid_flush, s_idex_bubble, s_link_write, s_busy, s_err;
  logic [1:0]  s_pc_sel;
  logic [1:0]  s_stall_cnt, s_flush_cnt;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [7:0]  outs;
    logic [15:0] sc;
    logic [15:0] fc;
    logic        err;
  } exp_t;

  exp_t exp_q[$];

  // {pc_write, pc_sel, ifid_write, ifid_flush, idex_bubble, link_write, busy}
  localparam logic [7:0] O_RST   = 8'b0_00_0_0000;
  localparam logic [7:0] O_IDLE  = 8'b1_00_1_0000;
  localparam logic [7:0] O_STALL = 8'b0_00_0_0100;
  localparam logic [7:0] O_BENT  = 8'b0_00_1_1000;
  localparam logic [7:0] O_WAIT  = 8'b0_00_1_1001;
  localparam logic [7:0] O_TAKEN = 8'b1_01_1_1001;
  localparam logic [7:0] O_NTAKE = 8'b1_00_1_1001;
  localparam logic [7:0] O_TMO   = 8'b1_00_1_1001;
  localparam logic [7:0] O_JR    = 8'b1_10_1_1000;
  localparam logic [7:0] O_JAL   = 8'b1_11_1_1010;
  localparam logic [7:0] O_JALR  = 8'b1_10_1_1010;
  localparam logic [7:0] O_J     = 8'b1_11_1_1000;

  // {stall, branch, jump, jump_type[1:0], resolved, taken}
  localparam logic [6:0] I_NONE  = 7'b000_00_00;
  localparam logic [6:0] I_STALL = 7'b100_00_00;
  localparam logic [6:0] I_BR    = 7'b010_00_00;
  localparam logic [6:0] I_JR    = 7'b001_00_00;
  localparam logic [6:0] I_JAL   = 7'b001_01_00;
  localparam logic [6:0] I_JALR  = 7'b001_10_00;
  localparam logic [6:0] I_J     = 7'b001_11_00;
  localparam logic [6:0] I_RES_T = 7'b000_00_11;
  localparam logic [6:0] I_RES_N = 7'b000_00_10;
  localparam logic [6:0] I_ALL   = 7'b111_01_00;
  localparam logic [6:0] I_WSTL  = 7'b111_11_00;

  wire [7:0] obs_outs = {pc_write, pc_sel, ifid_write, ifid_flush, idex_bubble, link_write, busy};

  always #5 clk = ~clk;

  pipeline_flow_ctrl #(.WAIT_MAX(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .stall_req(stall_req), .branch_req(branch_req), .jump_req(jump_req),
    .jump_type(jump_type), .branch_resolved(branch_resolved), .branch_taken(branch_taken),
    .pc_write(pc_write), .pc_sel(pc_sel), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
    .idex_bubble(idex_bubble), .link_write(link_write), .busy(busy),
    .br_timeout_err(br_timeout_err), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  pipeline_flow_ctrl #(.WAIT_MAX(4), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .stall_req(stall_req), .branch_req(branch_req), .jump_req(jump_req),
    .jump_type(jump_type), .branch_resolved(branch_resolved), .branch_taken(branch_taken),
    .pc_write(s_pc_write), .pc_sel(s_pc_sel), .ifid_write(s_ifid_write), .ifid_flush(s_ifid_flush),
    .idex_bubble(s_idex_bubble), .link_write(s_link_write), .busy(s_busy),
    .br_timeout_err(s_err), .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
  );

  task automatic apply_stimulus(input logic [6:0] in_vec, input logic [7:0] o,
                                input int sc, input int fc, input logic err);
    exp_t e;
    {stall_req, branch_req, jump_req, jump_type, branch_resolved, branch_taken} = in_vec;
    e.outs = o;
    e.sc   = 16'(sc);
    e.fc   = 16'(fc);
    e.err  = err;
    exp_q.push_back(e);
  endtask

  task automatic check_output(input string tag);
    exp_t e;
    if (exp_q.size() == 0) begin
      tests++;
      fails++;
      $error("FAIL %s: scoreboard empty, observed outs=%b required an entry", tag, obs_outs);
      return;
    end
    e = exp_q.pop_front();
    tests++;
    assert (obs_outs === e.outs) else begin
      fails++;
      $error("FAIL %s outs: observed=%b expected=%b", tag, obs_outs, e.outs);
    end
    tests++;
    assert (stall_cnt === e.sc) else begin
      fails++;
      $error("FAIL %s stall_cnt: observed=%0d expected=%0d", tag, stall_cnt, e.sc);
    end
    tests++;
    assert (flush_cnt === e.fc) else begin
      fails++;
      $error("FAIL %s flush_cnt: observed=%0d expected=%0d", tag, flush_cnt, e.fc);
    end
    tests++;
    assert (br_timeout_err === e.err) else begin
      fails++;
      $error("FAIL %s br_timeout_err: observed=%b expected=%b", tag, br_timeout_err, e.err);
    end
  endtask

  task automatic check_sat(input string tag, input logic [1:0] obs, input logic [1:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // One pipeline cycle: drive just after the edge, compare mid-cycle, advance.
  task automatic step(input string tag, input logic [6:0] in_vec, input logic [7:0] o,
                      input int sc, input int fc, input logic err);
    apply_stimulus(in_vec, o, sc, fc, err);
    @(negedge clk);
    check_output(tag);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input string tag);
    apply_stimulus(I_NONE, O_RST, 0, 0, 1'b0);
    rst = 1'b1;
    #1;
    check_output(tag);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    {stall_req, branch_req, jump_req, jump_type, branch_resolved, branch_taken} = I_NONE;
    #2;
    apply_stimulus(I_NONE, O_RST, 0, 0, 1'b0);
    check_output("reset_hold");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Async reset in the middle of a branch wait
    step("mid_br_entry", I_BR,   O_BENT, 0, 0, 1'b0);
    step("mid_br_w0",    I_NONE, O_WAIT, 0, 1, 1'b0);
    #1;
    apply_stimulus(I_NONE, O_WAIT, 0, 2, 1'b0);
    check_output("mid_br_w1_busy");
    rst = 1'b1;
    #1;
    apply_stimulus(I_NONE, O_RST, 0, 0, 1'b0);
    check_output("mid_br_async_rst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    step("after_rst_run", I_NONE, O_IDLE, 0, 0, 1'b0);

    // Load-use stall for three cycles
    do_reset("rst_stall");
    step("stall0", I_STALL, O_STALL, 0, 0, 1'b0);
    step("stall1", I_STALL, O_STALL, 1, 0, 1'b0);
    step("stall2", I_STALL, O_STALL, 2, 0, 1'b0);
    step("stall_done", I_NONE, O_IDLE, 3, 0, 1'b0);

    // Taken branch resolving in cycle 2; resolved in RUN is ignored
    do_reset("rst_branch");
    step("br_c0", I_BR,    O_BENT,  0, 0, 1'b0);
    step("br_c1", I_NONE,  O_WAIT,  0, 1, 1'b0);
    step("br_c2", I_RES_T, O_TAKEN, 0, 2, 1'b0);
    step("br_c3", I_NONE,  O_IDLE,  0, 3, 1'b0);
    step("run_res_ignored", I_RES_T, O_IDLE, 0, 3, 1'b0);

    // Jumps of every type
    do_reset("rst_jump");
    step("jal",       I_JAL,  O_JAL,  0, 0, 1'b0);
    step("jr",        I_JR,   O_JR,   0, 1, 1'b0);
    step("jump_idle", I_NONE, O_IDLE, 0, 2, 1'b0);
    step("jalr",      I_JALR, O_JALR, 0, 2, 1'b0);
    step("j",         I_J,    O_J,    0, 3, 1'b0);
    step("jump_end",  I_NONE, O_IDLE, 0, 4, 1'b0);

    // Timeout, then sticky error across later branches
    do_reset("rst_tmo");
    step("tmo_entry", I_BR,   O_BENT, 0, 0, 1'b0);
    step("tmo_w0",    I_NONE, O_WAIT, 0, 1, 1'b0);
    step("tmo_w1",    I_NONE, O_WAIT, 0, 2, 1'b0);
    step("tmo_w2",    I_NONE, O_WAIT, 0, 3, 1'b0);
    step("tmo_fire",  I_NONE, O_TMO,  0, 4, 1'b0);
    step("tmo_run0",  I_NONE, O_IDLE, 0, 5, 1'b1);
    step("tmo_run1",  I_NONE, O_IDLE, 0, 5, 1'b1);
    step("nt_entry",  I_BR,    O_BENT,  0, 5, 1'b1);
    step("nt_res",    I_RES_N, O_NTAKE, 0, 6, 1'b1);
    step("nt_run",    I_NONE,  O_IDLE,  0, 7, 1'b1);
    step("late_entry", I_BR,    O_BENT,  0, 7,  1'b1);
    step("late_w0",    I_WSTL,  O_WAIT,  0, 8,  1'b1);
    step("late_w1",    I_NONE,  O_WAIT,  0, 9,  1'b1);
    step("late_w2",    I_NONE,  O_WAIT,  0, 10, 1'b1);
    step("late_res",   I_RES_T, O_TAKEN, 0, 11, 1'b1);
    step("late_run",   I_NONE,  O_IDLE,  0, 12, 1'b1);

    // Simultaneous requests, then counter saturation on the CNT_W=2 copy
    do_reset("rst_prio");
    step("prio_all",  I_ALL,  O_STALL, 0, 0, 1'b0);
    step("prio_after", I_NONE, O_IDLE, 1, 0, 1'b0);
    do_reset("rst_sat");
    step("sat_s0", I_STALL, O_STALL, 0, 0, 1'b0);
    step("sat_s1", I_STALL, O_STALL, 1, 0, 1'b0);
    step("sat_s2", I_STALL, O_STALL, 2, 0, 1'b0);
    check_sat("sat_stall_at3", s_stall_cnt, 2'd3);
    step("sat_s3", I_STALL, O_STALL, 3, 0, 1'b0);
    step("sat_s4", I_STALL, O_STALL, 4, 0, 1'b0);
    step("sat_idle", I_NONE, O_IDLE, 5, 0, 1'b0);
    check_sat("sat_stall_hold", s_stall_cnt, 2'd3);
    for (int i = 0; i < 5; i++)
      step("sat_jump", I_J, O_J, 5, i, 1'b0);
    step("sat_jidle", I_NONE, O_IDLE, 5, 5, 1'b0);
    check_sat("sat_flush_hold", s_flush_cnt, 2'd3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
